// File: rtl/byte_serial_adder.sv
// Byte-serial flag-producing adder: WIDTH-bit operands pass one byte per clock,
// low byte first, through a single 8-bit add slice.
module byte_serial_adder #(
    parameter  int WIDTH = 16,
    localparam int BYTES = WIDTH / 8
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic [2:0]       i_Op,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic [3:0]       i_F,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [WIDTH-1:0] o_Result,
    output logic [3:0]       o_F
);

    // state | meaning
    // IDLE  | waiting for i_Start; outputs hold last result
    // RUN   | one operand byte added per clock, low byte first

    localparam int SW = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ADC   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_SBC   = 3'b011;
    localparam logic [2:0] OP_INC   = 3'b100;
    localparam logic [2:0] OP_DEC   = 3'b101;
    localparam logic [2:0] OP_ADDSP = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic             accept;
    logic             last_step;
    logic [SW-1:0]    step;

    logic [2:0]       op_norm;
    logic [WIDTH-1:0] b_sext;
    logic [WIDTH-1:0] b_prep;
    logic             cin_prep;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [2:0]       op_q;
    logic [3:0]       f_q;
    logic             carry_q;
    logic             zero_acc;
    logic             sp_h_q;
    logic             sp_c_q;
    logic             done_q;

    logic [4:0]       sum_lo;
    logic [4:0]       sum_hi;
    logic [7:0]       slice_sum;
    logic             c4;
    logic             c8;
    logic [WIDTH-1:0] res_next;
    logic             z_res;
    logic             sp_h;
    logic             sp_c;
    logic [3:0]       f_next;

    assign last_step = (state == RUN) && (step == SW'(BYTES - 1));

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_Start) state_next = RUN;
            RUN:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_Busy = (state == RUN);
        o_Done = done_q;
        accept = (state == IDLE) && i_Start;
    end

    // Operand B' and carry-in are resolved once, at acceptance.
    always_comb begin
        op_norm = (i_Op == 3'b111) ? OP_ADD : i_Op;
        b_sext = {WIDTH{i_B[7]}};
        b_sext[7:0] = i_B[7:0];
        b_prep = i_B;
        cin_prep = 1'b0;
        case (op_norm)
            OP_ADC: begin
                b_prep = i_B;
                cin_prep = i_F[0];
            end
            OP_SUB: begin
                b_prep = ~i_B;
                cin_prep = 1'b1;
            end
            OP_SBC: begin
                b_prep = ~i_B;
                cin_prep = ~i_F[0];
            end
            OP_INC:   b_prep = WIDTH'(1);
            OP_DEC:   b_prep = '1;
            OP_ADDSP: b_prep = b_sext;
            default:  b_prep = i_B;
        endcase
    end

    always_comb begin
        sum_lo = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_q};
        sum_hi = {1'b0, a_sh[7:4]} + {1'b0, b_sh[7:4]} + {4'b0000, sum_lo[4]};
        slice_sum = {sum_hi[3:0], sum_lo[3:0]};
        c4 = sum_lo[4];
        c8 = sum_hi[4];
    end

    // Earlier bytes sit in a shift register; the current byte enters at the top.
    generate
        if (BYTES > 1) begin : g_multi
            logic [WIDTH-9:0] res_sr;
            always_ff @(posedge i_Clk or posedge i_Reset) begin
                if (i_Reset) begin
                    res_sr <= '0;
                end else if (state == RUN) begin
                    res_sr <= res_next[WIDTH-1:8];
                end
            end
            assign res_next = {slice_sum, res_sr};
        end else begin : g_single
            assign res_next = slice_sum;
        end
    endgenerate

    always_comb begin
        z_res = ~(zero_acc | (|slice_sum));
        sp_h = (step == '0) ? c4 : sp_h_q;
        sp_c = (step == '0) ? c8 : sp_c_q;
        case (op_q)
            OP_ADD:           f_next = {f_q[3], 1'b0, c4, c8};
            OP_ADC:           f_next = {z_res, 1'b0, c4, c8};
            OP_SUB, OP_SBC:   f_next = {z_res, 1'b1, ~c4, ~c8};
            OP_INC, OP_DEC:   f_next = f_q;
            OP_ADDSP:         f_next = {2'b00, sp_h, sp_c};
            default:          f_next = {f_q[3], 1'b0, c4, c8};
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            op_q     <= OP_ADD;
            f_q      <= '0;
            carry_q  <= 1'b0;
            zero_acc <= 1'b0;
            sp_h_q   <= 1'b0;
            sp_c_q   <= 1'b0;
            step     <= '0;
            done_q   <= 1'b0;
            o_Result <= '0;
            o_F      <= '0;
        end else begin
            done_q <= last_step;
            if (accept) begin
                a_sh     <= i_A;
                b_sh     <= b_prep;
                op_q     <= op_norm;
                f_q      <= i_F;
                carry_q  <= cin_prep;
                zero_acc <= 1'b0;
                step     <= '0;
            end else if (state == RUN) begin
                a_sh     <= a_sh >> 8;
                b_sh     <= b_sh >> 8;
                carry_q  <= c8;
                zero_acc <= zero_acc | (|slice_sum);
                step     <= step + 1'b1;
                // SP+e8 flags come from the low byte only.
                if (step == '0) begin
                    sp_h_q <= c4;
                    sp_c_q <= c8;
                end
                if (last_step) begin
                    o_Result <= res_next;
                    o_F      <= f_next;
                end
            end
        end
    end

endmodule
